// File: rtl/clk_div_prog.sv
// Programmable clock-enable divider: one-cycle tick (imp) and near-50% enable (sq)
// with a shadowed divisor that switches over only at a period boundary.
module clk_div_prog #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_load,
   output logic             imp,
   output logic             sq,
   output logic [WIDTH-1:0] cnt_out,
   output logic [WIDTH-1:0] div_active,
   output logic             pending
);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] cnt_next;
   logic [WIDTH-1:0] div_next;
   logic [WIDTH-1:0] shadow_in;
   logic [WIDTH:0]   hi_next;
   logic             wrap;
   logic             apply;
   logic             sq_next;

   assign cnt_out = cnt;

   // Divisors 0 and 1 both mean "every cycle".
   assign shadow_in = (div_in == '0) ? WIDTH'(1) : div_in;

   always_comb begin
      wrap  = (cnt == div_active - WIDTH'(1));
      // While idle (en=0) there is no period to protect, so a pending divisor lands immediately.
      apply = pending & (wrap | ~en);

      div_next = div_active;
      cnt_next = cnt;
      if (apply) begin
         div_next = shadow;
         cnt_next = '0;
      end else if (en) begin
         cnt_next = wrap ? '0 : cnt + WIDTH'(1);
      end

      // HI = ceil(N/2), one bit wider so N=2^WIDTH-1 cannot overflow.
      hi_next = ({1'b0, div_next} + (WIDTH+1)'(1)) >> 1;
      sq_next = ({1'b0, cnt_next} < hi_next);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt        <= '0;
         div_active <= WIDTH'(DEFAULT_DIV);
         shadow     <= '0;
         pending    <= 1'b0;
         imp        <= 1'b0;
         sq         <= 1'b0;
      end else begin
         cnt        <= cnt_next;
         div_active <= div_next;
         imp        <= en & wrap;
         sq         <= sq_next;
         // A load coinciding with an apply refills the shadow, so pending stays set.
         if (div_load) begin
            shadow  <= shadow_in;
            pending <= 1'b1;
         end else if (apply) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: a behavioural model pushes expected outputs per edge,
// each scenario task pops and compares them after the edge.
module tb_clk_div_prog;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         en = 1'b0;
   logic [W-1:0] div_in = '0;
   logic         div_load = 1'b0;
   logic         imp, sq, pending;
   logic [W-1:0] cnt_out, div_active;

   int total = 0;
   int bad = 0;

   // expected {imp, sq, cnt, div_active, pending}
   logic [2*W+2:0] exp_q[$];
   logic [2*W+2:0] e, g;

   int m_cnt = 0, m_div = 5, m_sh = 0, m_pend = 0, m_imp = 0, m_sq = 0;

   clk_div_prog #(.WIDTH(W), .DEFAULT_DIV(5)) dut (
      .clk(clk), .reset(reset), .en(en), .div_in(div_in), .div_load(div_load),
      .imp(imp), .sq(sq), .cnt_out(cnt_out), .div_active(div_active), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic model_step();
      int at_end;
      if (!reset) begin
         m_cnt = 0; m_div = 5; m_sh = 0; m_pend = 0; m_imp = 0; m_sq = 0;
      end else begin
         at_end = (m_cnt + 1 == m_div);
         m_imp = (en && at_end) ? 1 : 0;
         if (m_pend != 0 && (!en || at_end != 0)) begin
            m_div = m_sh; m_cnt = 0; m_pend = 0;
         end else if (en) begin
            m_cnt = (at_end != 0) ? 0 : m_cnt + 1;
         end
         if (div_load) begin
            m_sh = (int'(div_in) < 2) ? 1 : int'(div_in);
            m_pend = 1;
         end
         m_sq = (m_cnt * 2 < m_div) ? 1 : 0;
      end
   endtask

   // advance one edge, queueing what the model says the DUT should show afterwards
   task automatic tick();
      model_step();
      exp_q.push_back({m_imp[0], m_sq[0], W'(m_cnt), W'(m_div), m_pend[0]});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; en = 1'b1; div_in = 8'd7; div_load = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         e = exp_q.pop_front(); g = {imp, sq, cnt_out, div_active, pending}; total++;
         if (g !== e) begin bad++; $display("FAIL reset cyc%0d got=%h want=%h", i, g, e); end
      end
      div_load = 1'b0;
      total++;
      if (div_active !== 8'd5 || sq !== 1'b0 || pending !== 1'b0) begin
         bad++; $display("FAIL reset_state div=%0d sq=%b pend=%b want 5/0/0", div_active, sq, pending);
      end
   endtask

   task automatic test_default();
      int n_imp = 0;
      reset = 1'b1; en = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         n_imp += int'(imp);
         e = exp_q.pop_front(); g = {imp, sq, cnt_out, div_active, pending}; total++;
         if (g !== e) begin bad++; $display("FAIL default cyc%0d got=%h want=%h", i, g, e); end
      end
      total++;
      if (n_imp !== 3 || cnt_out !== 8'd0 || imp !== 1'b1) begin
         bad++; $display("FAIL default_period imps=%0d cnt=%0d imp=%b want 3/0/1", n_imp, cnt_out, imp);
      end
   endtask

   task automatic test_en_hold();
      for (int i = 0; i < 9; i++) begin
         en = (i >= 2 && i < 6) ? 1'b0 : 1'b1;
         tick();
         e = exp_q.pop_front(); g = {imp, sq, cnt_out, div_active, pending}; total++;
         if (g !== e) begin bad++; $display("FAIL en_hold cyc%0d got=%h want=%h", i, g, e); end
         if (i == 5) begin
            total++;
            if (cnt_out !== 8'd2 || imp !== 1'b0 || sq !== 1'b1) begin
               bad++; $display("FAIL en_hold_state cnt=%0d imp=%b sq=%b want 2/0/1", cnt_out, imp, sq);
            end
         end
      end
      en = 1'b1;
   endtask

   task automatic test_reload8();
      int n_imp = 0, n_sq = 0;
      for (int i = 0; i < 26; i++) begin
         div_load = (i == 1); div_in = 8'd8;
         tick();
         if (i >= 10) begin n_imp += int'(imp); n_sq += int'(sq); end
         e = exp_q.pop_front(); g = {imp, sq, cnt_out, div_active, pending}; total++;
         if (g !== e) begin bad++; $display("FAIL reload8 cyc%0d got=%h want=%h", i, g, e); end
      end
      div_load = 1'b0;
      total++;
      if (n_imp !== 2 || n_sq !== 8 || div_active !== 8'd8 || pending !== 1'b0) begin
         bad++; $display("FAIL reload8_period imps=%0d sqhi=%0d div=%0d pend=%b want 2/8/8/0",
                         n_imp, n_sq, div_active, pending);
      end
   endtask

   task automatic test_div_one();
      for (int i = 0; i < 16; i++) begin
         div_load = (i < 2); div_in = (i == 0) ? 8'd0 : 8'd1;
         tick();
         e = exp_q.pop_front(); g = {imp, sq, cnt_out, div_active, pending}; total++;
         if (g !== e) begin bad++; $display("FAIL div_one cyc%0d got=%h want=%h", i, g, e); end
      end
      div_load = 1'b0;
      total++;
      if (div_active !== 8'd1 || imp !== 1'b1 || sq !== 1'b1 || cnt_out !== 8'd0) begin
         bad++; $display("FAIL div_one_state div=%0d imp=%b sq=%b cnt=%0d want 1/1/1/0",
                         div_active, imp, sq, cnt_out);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) begin
         div_load = (i < 2); div_in = (i == 0) ? 8'd6 : 8'd3;
         tick();
         e = exp_q.pop_front(); g = {imp, sq, cnt_out, div_active, pending}; total++;
         if (g !== e) begin bad++; $display("FAIL b2b cyc%0d got=%h want=%h", i, g, e); end
         if (i == 1) begin
            total++;
            if (div_active !== 8'd6 || pending !== 1'b1) begin
               bad++; $display("FAIL b2b_overlap div=%0d pend=%b want 6/1", div_active, pending);
            end
         end
      end
      div_load = 1'b0;
      total++;
      if (div_active !== 8'd3 || pending !== 1'b0) begin
         bad++; $display("FAIL b2b_final div=%0d pend=%b want 3/0", div_active, pending);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         div_load = (i == 0); div_in = 8'd9;
         reset = (i == 1) ? 1'b0 : 1'b1;
         tick();
         e = exp_q.pop_front(); g = {imp, sq, cnt_out, div_active, pending}; total++;
         if (g !== e) begin bad++; $display("FAIL reset_mid cyc%0d got=%h want=%h", i, g, e); end
         if (i == 1) begin
            total++;
            if (cnt_out !== 8'd0 || imp !== 1'b0 || sq !== 1'b0 || pending !== 1'b0 || div_active !== 8'd5) begin
               bad++; $display("FAIL reset_mid_state cnt=%0d imp=%b sq=%b pend=%b div=%0d want 0/0/0/0/5",
                               cnt_out, imp, sq, pending, div_active);
            end
         end
      end
      div_load = 1'b0; reset = 1'b1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 200; i++) begin
         en = ($urandom_range(0, 3) != 0);
         div_load = ($urandom_range(0, 15) == 0);
         div_in = W'($urandom_range(0, 12));
         reset = ($urandom_range(0, 99) != 0);
         tick();
         e = exp_q.pop_front(); g = {imp, sq, cnt_out, div_active, pending}; total++;
         if (g !== e) begin bad++; $display("FAIL random cyc%0d got=%h want=%h", i, g, e); end
      end
      div_load = 1'b0; reset = 1'b1; en = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_default();
      test_en_hold();
      test_reload8();
      test_div_one();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
